// File: rtl/i2c_target_pkg.sv
// ============================================================================
// i2c_target_pkg : shared types and register-port widths for the I2C target
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package i2c_target_pkg;

    localparam int REG_AW = 8;
    localparam int REG_DW = 8;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_ADDR     = 4'd1,
        ST_ADDR_ACK = 4'd2,
        ST_PTR      = 4'd3,
        ST_PTR_ACK  = 4'd4,
        ST_WR       = 4'd5,
        ST_WR_ACK   = 4'd6,
        ST_RD       = 4'd7,
        ST_RD_ACK   = 4'd8,
        ST_IGNORE   = 4'd9
    } state_t;

endpackage

`default_nettype wire

// File: rtl/i2c_target_if.sv
// ============================================================================
// i2c_target_if : pad-side I2C lines plus byte-wide register port
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface i2c_target_if;
    import i2c_target_pkg::*;

    logic              scl_i;
    logic              sda_i;
    logic              scl_o;
    logic              scl_oe_o;
    logic              sda_o;
    logic              sda_oe_o;
    logic              reg_we_o;
    logic              reg_re_o;
    logic [REG_AW-1:0] reg_addr_o;
    logic [REG_DW-1:0] reg_wdata_o;
    logic [REG_DW-1:0] reg_rdata_i;
    logic              busy_o;
    logic              stop_o;

    modport slave (
        input  scl_i, sda_i, reg_rdata_i,
        output scl_o, scl_oe_o, sda_o, sda_oe_o,
        output reg_we_o, reg_re_o, reg_addr_o, reg_wdata_o, busy_o, stop_o
    );

    modport master (
        output scl_i, sda_i, reg_rdata_i,
        input  scl_o, scl_oe_o, sda_o, sda_oe_o,
        input  reg_we_o, reg_re_o, reg_addr_o, reg_wdata_o, busy_o, stop_o
    );

endinterface

`default_nettype wire

// File: rtl/i2c_target_sync.sv
// ============================================================================
// i2c_target_sync : 2-flop synchronizer, optional stability filter, edge detect
// Optional filter: I2C_TARGET_FILTER_EN.  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_target_sync #(
    parameter int FILT_LEN = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;
    logic clean;
    logic prev;

    // Idle bus level is high, so reset to 1 to avoid a spurious edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b1;
            sync <= 1'b1;
        end else begin
            meta <= din;
            sync <= meta;
        end
    end

`ifdef I2C_TARGET_FILTER_EN
    localparam int CNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            clean <= 1'b1;
            cnt   <= '0;
        end else if (sync == clean) begin
            cnt <= '0;
        end else if (cnt == CNT_W'(FILT_LEN - 1)) begin
            clean <= sync;
            cnt   <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end
`else
    // Filter compiled out: FILT_LEN has no effect on the path.
    if (FILT_LEN >= 0) begin : g_bypass
        assign clean = sync;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            prev <= 1'b1;
        end else begin
            prev <= clean;
        end
    end

    assign level = clean;
    assign rise  = clean & ~prev;
    assign fall  = ~clean & prev;

endmodule

`default_nettype wire

// File: rtl/i2c_target.sv
// ============================================================================
// i2c_target : I2C target with 8-bit register pointer and byte register port
// Optional input filter: I2C_TARGET_FILTER_EN.  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_target
    import i2c_target_pkg::*;
#(
    parameter logic [6:0] TGT_ADDR = 7'h50,
    parameter int         FILT_LEN = 3
) (
    input  logic         clk_i,
    input  logic         rst_i,
    i2c_target_if.slave  bus
);

    logic scl, scl_rise, scl_fall;
    logic sda, sda_rise, sda_fall;
    logic start_det, stop_det;

    i2c_target_sync #(.FILT_LEN(FILT_LEN)) u_scl_sync (
        .clk(clk_i), .rst(rst_i), .din(bus.scl_i),
        .level(scl), .rise(scl_rise), .fall(scl_fall)
    );

    i2c_target_sync #(.FILT_LEN(FILT_LEN)) u_sda_sync (
        .clk(clk_i), .rst(rst_i), .din(bus.sda_i),
        .level(sda), .rise(sda_rise), .fall(sda_fall)
    );

    assign start_det = sda_fall & scl;
    assign stop_det  = sda_rise & scl;

    state_t            state, state_n;
    logic [3:0]        bit_cnt, bit_cnt_n;
    logic [7:0]        shift, shift_n;
    logic [REG_AW-1:0] ptr, ptr_n;
    logic [REG_DW-1:0] wdata, wdata_n;
    logic              rw, rw_n;
    logic              sda_oe, sda_oe_n;
    logic              busy, busy_n;
    logic              stop_p, stop_n;
    logic              we, we_n;
    logic              re, re_n;
    logic              load;
    logic [7:0]        byte_in;

    assign byte_in = {shift[6:0], sda};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            shift   <= '0;
            ptr     <= '0;
            wdata   <= '0;
            rw      <= 1'b0;
            sda_oe  <= 1'b0;
            busy    <= 1'b0;
            stop_p  <= 1'b0;
            we      <= 1'b0;
            re      <= 1'b0;
            load    <= 1'b0;
        end else begin
            state   <= state_n;
            bit_cnt <= bit_cnt_n;
            shift   <= shift_n;
            ptr     <= ptr_n;
            wdata   <= wdata_n;
            rw      <= rw_n;
            sda_oe  <= sda_oe_n;
            busy    <= busy_n;
            stop_p  <= stop_n;
            we      <= we_n;
            re      <= re_n;
            load    <= re;
        end
    end

    // ACK states use bit_cnt as a phase flag: 0 before the 9th SCL rise, 1 after.
    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shift_n   = shift;
        ptr_n     = ptr;
        wdata_n   = wdata;
        rw_n      = rw;
        sda_oe_n  = sda_oe;
        busy_n    = busy;
        stop_n    = 1'b0;
        we_n      = 1'b0;
        re_n      = 1'b0;

        if (load) begin
            shift_n = bus.reg_rdata_i;
        end

        if (stop_det) begin
            state_n   = ST_IDLE;
            sda_oe_n  = 1'b0;
            busy_n    = 1'b0;
            stop_n    = busy;
            bit_cnt_n = '0;
        end else if (start_det) begin
            state_n   = ST_ADDR;
            sda_oe_n  = 1'b0;
            bit_cnt_n = '0;
        end else begin
            case (state)
                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_n   = byte_in;
                        bit_cnt_n = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            bit_cnt_n = '0;
                            rw_n      = sda;
                            if (shift[6:0] == TGT_ADDR && TGT_ADDR != 7'd0) begin
                                state_n = ST_ADDR_ACK;
                                busy_n  = 1'b1;
                                re_n    = sda;
                            end else begin
                                state_n = ST_IGNORE;
                            end
                        end
                    end
                end
                ST_ADDR_ACK, ST_PTR_ACK, ST_WR_ACK: begin
                    if (state == ST_WR_ACK && we) begin
                        ptr_n = ptr + 8'd1;
                    end
                    if (scl_rise) begin
                        bit_cnt_n = 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt == 4'd0) begin
                            sda_oe_n = 1'b1;
                        end else begin
                            bit_cnt_n = '0;
                            if (state == ST_ADDR_ACK && rw) begin
                                state_n  = ST_RD;
                                sda_oe_n = ~shift[7];
                            end else begin
                                state_n  = (state == ST_ADDR_ACK) ? ST_PTR : ST_WR;
                                sda_oe_n = 1'b0;
                            end
                        end
                    end
                end
                ST_PTR, ST_WR: begin
                    if (scl_rise) begin
                        shift_n   = byte_in;
                        bit_cnt_n = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            bit_cnt_n = '0;
                            if (state == ST_PTR) begin
                                ptr_n   = byte_in;
                                state_n = ST_PTR_ACK;
                            end else begin
                                we_n    = 1'b1;
                                wdata_n = byte_in;
                                state_n = ST_WR_ACK;
                            end
                        end
                    end
                end
                ST_RD: begin
                    if (scl_rise) begin
                        bit_cnt_n = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            bit_cnt_n = '0;
                            state_n   = ST_RD_ACK;
                        end
                    end else if (scl_fall) begin
                        shift_n  = {shift[6:0], 1'b0};
                        sda_oe_n = ~shift[6];
                    end
                end
                ST_RD_ACK: begin
                    if (scl_rise && bit_cnt == 4'd0) begin
                        ptr_n = ptr + 8'd1;
                        if (!sda) begin
                            re_n      = 1'b1;
                            bit_cnt_n = 4'd1;
                        end else begin
                            state_n = ST_IGNORE;
                        end
                    end else if (scl_fall) begin
                        if (bit_cnt == 4'd0) begin
                            sda_oe_n = 1'b0;
                        end else begin
                            bit_cnt_n = '0;
                            state_n   = ST_RD;
                            sda_oe_n  = ~shift[7];
                        end
                    end
                end
                ST_IDLE, ST_IGNORE: begin
                    state_n = state;
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end
    end

    assign bus.scl_o       = 1'b0;
    assign bus.scl_oe_o    = 1'b0;
    assign bus.sda_o       = 1'b0;
    assign bus.sda_oe_o    = sda_oe;
    assign bus.reg_we_o    = we;
    assign bus.reg_re_o    = re;
    assign bus.reg_addr_o  = ptr;
    assign bus.reg_wdata_o = wdata;
    assign bus.busy_o      = busy;
    assign bus.stop_o      = stop_p;

endmodule

`default_nettype wire

// File: tb/tb_i2c_target.sv
// ============================================================================
// tb_i2c_target : bit-level I2C controller model with register-port scoreboard
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_i2c_target;
    import i2c_target_pkg::*;

    localparam int Q = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic scl_m = 1'b1;
    logic sda_m = 1'b1;
    logic quiet = 1'b0;
    logic [7:0] rdata_q = 8'h00;

    int vectors = 0;
    int errors = 0;
    int stop_seen = 0;
    int exp_stops = 0;

    logic [15:0] exp_wr[$];
    logic [7:0]  exp_rd[$];

    i2c_target_if bus();

    assign bus.scl_i       = scl_m;
    assign bus.sda_i       = sda_m & ~bus.sda_oe_o;
    assign bus.reg_rdata_i = rdata_q;

    always #5 clk = ~clk;

    // Register bank: data valid one cycle after the read strobe.
    always @(posedge clk) begin
        if (bus.reg_re_o) rdata_q <= bus.reg_addr_o ^ 8'h5A;
    end

    i2c_target #(.TGT_ADDR(7'h50), .FILT_LEN(3)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus(bus)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
        end
    endtask

    // Per-cycle compare against the scoreboard queues.
    initial begin
        logic [15:0] ew;
        logic [7:0]  er;
        forever begin
            @(negedge clk);
            check("const_outputs", 32'({bus.scl_o, bus.scl_oe_o, bus.sda_o}), 32'(0));
            if (quiet) check("sda_quiet", 32'(bus.sda_oe_o), 32'(0));
            if (bus.reg_we_o) begin
                check("we_expected", 32'(exp_wr.size() != 0), 32'(1));
                if (exp_wr.size() != 0) begin
                    ew = exp_wr.pop_front();
                    check("wr_addr_data", 32'({bus.reg_addr_o, bus.reg_wdata_o}), 32'(ew));
                end
            end
            if (bus.reg_re_o) begin
                check("re_expected", 32'(exp_rd.size() != 0), 32'(1));
                if (exp_rd.size() != 0) begin
                    er = exp_rd.pop_front();
                    check("rd_addr", 32'(bus.reg_addr_o), 32'(er));
                end
            end
            if (bus.stop_o) stop_seen++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, output logic s, input logic glitch);
        cyc(Q);
        sda_m = b;
        if (glitch) begin
            cyc(2); scl_m = 1'b1;
            cyc(1); scl_m = 1'b0;
            cyc(Q - 3);
        end else begin
            cyc(Q);
        end
        scl_m = 1'b1;
        cyc(Q);
        s = bus.sda_i;
        cyc(Q);
        scl_m = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack, input logic glitch0);
        logic s;
        for (int i = 7; i >= 0; i--) send_bit(b[i], s, glitch0 && (i == 7));
        send_bit(1'b1, s, 1'b0);
        ack = ~s;
    endtask

    task automatic read_byte(input logic ack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            send_bit(1'b1, s, 1'b0);
            d[i] = s;
        end
        send_bit(~ack, s, 1'b0);
    endtask

    task automatic i2c_start();
        cyc(Q); sda_m = 1'b1;
        cyc(Q); scl_m = 1'b1;
        cyc(Q); sda_m = 1'b0;
        cyc(Q); scl_m = 1'b0;
    endtask

    task automatic i2c_stop();
        cyc(Q); sda_m = 1'b0;
        cyc(Q); scl_m = 1'b1;
        cyc(Q); sda_m = 1'b1;
        cyc(Q);
    endtask

    initial begin
        logic ack;
        logic [7:0] d;
        logic s;

        // Reset values
        cyc(5);
        check("rst_sda_oe", 32'(bus.sda_oe_o), 32'(0));
        check("rst_strobes", 32'({bus.reg_we_o, bus.reg_re_o}), 32'(0));
        check("rst_addr", 32'(bus.reg_addr_o), 32'(0));
        check("rst_wdata", 32'(bus.reg_wdata_o), 32'(0));
        check("rst_busy_stop", 32'({bus.busy_o, bus.stop_o}), 32'(0));
        rst = 1'b0;
        cyc(5);

        // Write pointer 0x10 then two data bytes
        i2c_start();
        write_byte(8'hA0, ack, 1'b0); check("t1_ack_addr", 32'(ack), 32'(1));
        write_byte(8'h10, ack, 1'b0); check("t1_ack_ptr", 32'(ack), 32'(1));
        check("t1_busy", 32'(bus.busy_o), 32'(1));
        exp_wr.push_back(16'h10A5);
        write_byte(8'hA5, ack, 1'b0); check("t1_ack_d0", 32'(ack), 32'(1));
        exp_wr.push_back(16'h113C);
        write_byte(8'h3C, ack, 1'b0); check("t1_ack_d1", 32'(ack), 32'(1));
        i2c_stop(); exp_stops++;
        cyc(4);
        check("t1_stop_count", 32'(stop_seen), 32'(exp_stops));
        check("t1_busy_clear", 32'(bus.busy_o), 32'(0));

        // Pointer 0xFF, repeated START, read two bytes with wrap
        i2c_start();
        write_byte(8'hA0, ack, 1'b0); check("t2_ack_addr", 32'(ack), 32'(1));
        write_byte(8'hFF, ack, 1'b0); check("t2_ack_ptr", 32'(ack), 32'(1));
        i2c_start();
        exp_rd.push_back(8'hFF);
        exp_rd.push_back(8'h00);
        write_byte(8'hA1, ack, 1'b0); check("t2_ack_raddr", 32'(ack), 32'(1));
        read_byte(1'b1, d); check("t2_rd0", 32'(d), 32'(8'hA5));
        read_byte(1'b0, d); check("t2_rd1", 32'(d), 32'(8'h5A));
        cyc(2);
        check("t2_released", 32'(bus.sda_oe_o), 32'(0));
        i2c_stop(); exp_stops++;
        cyc(4);
        check("t2_stop_count", 32'(stop_seen), 32'(exp_stops));
        check("t2_ptr", 32'(bus.reg_addr_o), 32'(8'h01));

        // Address 0x51: no ACK, no strobes
        i2c_start();
        quiet = 1'b1;
        write_byte(8'hA2, ack, 1'b0); check("t3_nack_addr", 32'(ack), 32'(0));
        for (int i = 0; i < 3; i++) begin
            write_byte(8'h11 * 8'(i + 1), ack, 1'b0);
            check("t3_nack_data", 32'(ack), 32'(0));
        end
        i2c_stop();
        quiet = 1'b0;
        cyc(4);
        check("t3_stop_count", 32'(stop_seen), 32'(exp_stops));
        check("t3_ptr", 32'(bus.reg_addr_o), 32'(8'h01));

        // STOP after 4 bits of a data byte
        i2c_start();
        write_byte(8'hA0, ack, 1'b0); check("t4_ack_addr", 32'(ack), 32'(1));
        write_byte(8'h30, ack, 1'b0); check("t4_ack_ptr", 32'(ack), 32'(1));
        for (int i = 0; i < 4; i++) send_bit(1'b1, s, 1'b0);
        i2c_stop(); exp_stops++;
        cyc(4);
        check("t4_ptr", 32'(bus.reg_addr_o), 32'(8'h30));
        check("t4_busy", 32'(bus.busy_o), 32'(0));
        check("t4_stop_count", 32'(stop_seen), 32'(exp_stops));

        // One-cycle SCL glitch in the low phase of the first data bit
        i2c_start();
        write_byte(8'hA0, ack, 1'b0); check("t6_ack_addr", 32'(ack), 32'(1));
        write_byte(8'h20, ack, 1'b0); check("t6_ack_ptr", 32'(ack), 32'(1));
`ifdef I2C_TARGET_FILTER_EN
        exp_wr.push_back(16'h2081);
        write_byte(8'h81, ack, 1'b1); check("t6_ack_glitch", 32'(ack), 32'(1));
`else
        // The glitch samples bit 7 twice: byte seen as 0xC0, ACK lands one slot early.
        exp_wr.push_back(16'h20C0);
        write_byte(8'h81, ack, 1'b1); check("t6_ack_glitch", 32'(ack), 32'(0));
`endif
        i2c_stop(); exp_stops++;
        cyc(4);
        check("t6_stop_count", 32'(stop_seen), 32'(exp_stops));
        check("t6_ptr", 32'(bus.reg_addr_o), 32'(8'h21));

        // Reset while the address ACK is being driven
        i2c_start();
        for (int i = 7; i >= 0; i--) send_bit(8'hA0 >> i, s, 1'b0);
        cyc(6);
        check("t5_ack_driven", 32'(bus.sda_oe_o), 32'(1));
        rst = 1'b1;
        cyc(1);
        check("t5_sda_oe", 32'(bus.sda_oe_o), 32'(0));
        check("t5_ptr", 32'(bus.reg_addr_o), 32'(0));
        check("t5_busy", 32'(bus.busy_o), 32'(0));
        cyc(2);
        rst = 1'b0;
        sda_m = 1'b1;
        cyc(Q); scl_m = 1'b1;
        cyc(Q);

        // Read without a preceding write uses the current pointer (0)
        i2c_start();
        exp_rd.push_back(8'h00);
        write_byte(8'hA1, ack, 1'b0); check("t7_ack_raddr", 32'(ack), 32'(1));
        read_byte(1'b0, d); check("t7_rd0", 32'(d), 32'(8'h5A));
        i2c_stop(); exp_stops++;
        cyc(4);
        check("t7_stop_count", 32'(stop_seen), 32'(exp_stops));

        check("wr_queue_empty", 32'(exp_wr.size()), 32'(0));
        check("rd_queue_empty", 32'(exp_rd.size()), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/i2c_target.md
# i2c_target

I2C target (slave) responder, the bus-side counterpart of the peripheral's I2C controller. It decodes START, STOP and repeated START on synchronized SCL/SDA and matches a 7-bit address. Write transfers load an 8-bit register pointer and then emit byte writes on a simple register port. Read transfers fetch bytes from that port and shift them out, with pointer auto-increment. It sits between the pad open-drain buffers and a byte-wide register bank or mailbox.

## Interface
- `TGT_ADDR`, default 7'h50: the 7-bit address this target answers to.
- `FILT_LEN`, default 3: glitch-filter depth in clk_i cycles; used only with the filter macro.
- `clk_i` in 1: system clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `scl_i` in 1: SCL pad input.
- `sda_i` in 1: SDA pad input.
- `scl_o` out 1: constant 0.
- `scl_oe_o` out 1: constant 0; this block does no clock stretching.
- `sda_o` out 1: constant 0; open-drain.
- `sda_oe_o` out 1: 1 pulls SDA low.
- `reg_we_o` out 1: one-cycle write strobe.
- `reg_re_o` out 1: one-cycle read strobe.
- `reg_addr_o` out 8: register pointer.
- `reg_wdata_o` out 8: write data.
- `reg_rdata_i` in 8: read data, valid exactly 1 cycle after `reg_re_o`.
- `busy_o` out 1: high from START to STOP while addressed.
- `stop_o` out 1: one-cycle pulse on STOP after an addressed transfer.

## Operation
- Front end: 2-flop synchronizer on each of SCL and SDA, followed by edge detection.
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - Bits are sampled on SCL rise; `sda_oe_o` changes only after an SCL fall.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR, WR_ACK, RD, RD_ACK, IGNORE.
- IDLE: START goes to ADDR and clears the bit counter.
- ADDR: after 8 bits, compare the top 7 bits with `TGT_ADDR`.
  - Match: go to ADDR_ACK and drive ACK (`sda_oe_o`=1) from the next SCL fall to the following SCL fall.
  - Mismatch: go to IGNORE and leave SDA released.
- ADDR_ACK then branches on the R/W bit.
  - W=0: go to PTR. The first data byte loads the pointer and is ACKed (PTR_ACK). Each later byte is WR: ACK it, pulse `reg_we_o` with `reg_addr_o`=pointer and `reg_wdata_o`=byte on the cycle the 8th bit is sampled, then pointer+1 (WR_ACK).
  - R=1: pulse `reg_re_o` at ADDR_ACK entry and capture `reg_rdata_i` into the shift register. Shift MSB first, changing `sda_oe_o`=~bit after each SCL fall.
- RD_ACK: release SDA and sample the controller's ACK on the 9th SCL rise. The pointer increments after every transmitted byte.
  - ACK: pulse `reg_re_o` at the new pointer and continue with RD.
  - NACK: go to IGNORE.
- Pointer is 8 bits and wraps 0xFF to 0x00. It persists across transfers; a read without a preceding write uses the last pointer.
- STOP in any state: go to IDLE, `sda_oe_o`=0, clear `busy_o`, and pulse `stop_o` if the transfer was addressed.
- START in any non-IDLE state (repeated START): go to ADDR and release SDA. The pointer is kept.
- A partial byte at STOP or START is discarded, with no strobe.
- General call (address 0) and 10-bit addressing are not supported; both get NACK.

## Timing
- Reset values: every output 0; pointer 0; state IDLE.
- Reset asserted mid-transfer: `sda_oe_o`=0 on the next cycle, with no strobes.
- Input latency: 2 cycles (2+FILT_LEN with the filter).
- SDA drive change: 1 cycle after the synchronized SCL fall is detected.
- Clock ratio: clk_i ≥ 8× SCL frequency, and ≥ (8+FILT_LEN)× with the filter.
- Read-data turnaround: `reg_rdata_i` is captured 1 cycle after `reg_re_o`, always before the next SCL fall under the ratio above.
- A START and a STOP detected in the same cycle are impossible; if both arrive, STOP wins.

## Configuration
- Macro: `I2C_TARGET_FILTER_EN`.
- Defined: each synchronized input passes a FILT_LEN-cycle stability filter, and the output changes only after FILT_LEN equal consecutive samples.
- Undefined: no filter; a glitch of 1 cycle or longer propagates.

## Structure
- `i2c_target_pkg` holds the state enum, `REG_AW`=8, and `REG_DW`=8.
- Sub-module `i2c_target_sync` contains the synchronizer, the optional filter and the rise/fall detect. It is instantiated once for SCL and once for SDA.

## Test plan
- Write 0x50+W, ptr 0x10, 0xA5, 0x3C, STOP. Expect 4 ACKs, `reg_we_o` at 0x10=A5 and 0x11=3C, and a `stop_o` pulse.
- Write ptr 0xFF, repeated START, 0x50+R, read 2 bytes (ACK then NACK) against a model returning addr^0x5A. Expect bytes 0xA5 then 0x5A (pointer wraps), and SDA released after the NACK.
- Address 0x51 with a write of 3 bytes. Expect `sda_oe_o` to stay 0 and no strobes.
- STOP after 4 bits of a data byte. Expect IDLE, no `reg_we_o`, and the pointer unchanged.
- Assert `rst_i` during the ADDR_ACK low phase. Expect `sda_oe_o`=0 on the next cycle and pointer 0.
- 1-cycle SCL glitch during a data bit. With the macro: ignored and the byte is correct. Without the macro: the bit count is corrupted.
